// File: rtl/julia_pkg.sv
// ----------------------------------------------------------------------------
// julia_pkg : shared fixed-point formats and state encoding for the Julia
//             iterator datapath.
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package julia_pkg;

  localparam int FRAC_BITS = 28;
  localparam logic [35:0] ESC_LIMIT = 36'h0_4000_0000;

  localparam int c_DATA_W = 32;   // Q4.28 operands
  localparam int c_PROD_W = 64;   // full multiplier product
  localparam int c_WIDE_W = 36;   // Q8.28 squared terms
  localparam int c_MAG_W  = 37;   // |z|^2 sum with carry
  localparam int c_CNT_W  = 20;

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_LOAD_IM  = 3'd1;
  localparam logic [2:0] c_ST_MUL_RR   = 3'd2;
  localparam logic [2:0] c_ST_MUL_II   = 3'd3;
  localparam logic [2:0] c_ST_MUL_RI   = 3'd4;
  localparam logic [2:0] c_ST_SUM      = 3'd5;
  localparam logic [2:0] c_ST_WRITE_RE = 3'd6;
  localparam logic [2:0] c_ST_WRITE_IM = 3'd7;

endpackage

`default_nettype wire

// File: rtl/julia_mul.sv
// ----------------------------------------------------------------------------
// julia_mul : registered signed 32x32->64 multiplier, one cycle of latency.
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module julia_mul (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic signed [31:0] i_A,
  input  logic signed [31:0] i_B,
  output logic signed [63:0] o_P
);

  logic signed [63:0] product_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      product_q <= '0;
    end else begin
      product_q <= i_A * i_B;
    end
  end

  assign o_P = product_q;

endmodule

`default_nettype wire

// File: rtl/julia_iterator.sv
// ----------------------------------------------------------------------------
// julia_iterator : one z <- z^2 + c step per (zr, zi) pair read from a FIFO,
//                  with escape detection and freezing of escaped pixels.
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module julia_iterator #(
  parameter int          FRAC_BITS = julia_pkg::FRAC_BITS,
  parameter logic [35:0] ESC_LIMIT = julia_pkg::ESC_LIMIT
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [31:0] i_C_Re,
  input  logic [31:0] i_C_Im,
  input  logic [31:0] i_In_Q,
  input  logic        i_In_Empty,
  output logic        o_In_Rdreq,
  output logic [31:0] o_Out_Data,
  output logic        o_Out_Wrreq,
  input  logic        i_Out_Full,
  output logic        o_Busy,
  output logic [19:0] o_Escape_Count
);

  import julia_pkg::*;

  logic [2:0]              state_q, state_d;
  logic [c_DATA_W-1:0]     zr_q, zi_q, cre_q, cim_q, nzi_q, out_q;
  logic [c_WIDE_W-1:0]     rr_q, ii_q;
  logic [c_CNT_W-1:0]      cnt_q;

  logic signed [c_DATA_W-1:0] mul_a, mul_b;
  logic signed [c_PROD_W-1:0] prod;
  logic [c_WIDE_W-1:0]        prod_q828, diff;
  logic [c_MAG_W-1:0]         mag;
  logic [c_DATA_W-1:0]        new_zr, new_zi;
  logic                       escaped, rd_ok, wr_ok, in_write;

  julia_mul u_mul (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_A     (mul_a),
    .i_B     (mul_b),
    .o_P     (prod)
  );

  always_comb begin
    mul_a = zr_q;
    mul_b = zr_q;
    case (state_q)
      c_ST_MUL_II: begin mul_a = zi_q; mul_b = zi_q; end
      c_ST_MUL_RI: begin mul_a = zr_q; mul_b = zi_q; end
      default:     begin mul_a = zr_q; mul_b = zr_q; end
    endcase
  end

  // Product arriving in SUM is zr*zi; rr and ii were captured on the two cycles before.
  assign prod_q828 = prod[FRAC_BITS+c_WIDE_W-1:FRAC_BITS];
  assign mag       = {rr_q[c_WIDE_W-1], rr_q} + {ii_q[c_WIDE_W-1], ii_q};
  assign escaped   = $signed(mag) >= $signed({1'b0, ESC_LIMIT});
  assign diff      = rr_q - ii_q;
  assign new_zr    = diff[c_DATA_W-1:0] + cre_q;
  assign new_zi    = {prod_q828[c_DATA_W-2:0], 1'b0} + cim_q;

  logic w_unused;
  assign w_unused = ^{prod[c_PROD_W-1:FRAC_BITS+c_WIDE_W], prod[FRAC_BITS-1:0],
                      diff[c_WIDE_W-1:c_DATA_W], prod_q828[c_WIDE_W-1:c_DATA_W-1]};

  assign in_write = (state_q == c_ST_WRITE_RE) || (state_q == c_ST_WRITE_IM);
  assign rd_ok    = !i_Reset && !i_In_Empty &&
                    ((state_q == c_ST_IDLE) || (state_q == c_ST_LOAD_IM));
  assign wr_ok    = !i_Reset && !i_Out_Full && in_write;

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:     if (rd_ok) state_d = c_ST_LOAD_IM;
      c_ST_LOAD_IM:  if (rd_ok) state_d = c_ST_MUL_RR;
      c_ST_MUL_RR:   state_d = c_ST_MUL_II;
      c_ST_MUL_II:   state_d = c_ST_MUL_RI;
      c_ST_MUL_RI:   state_d = c_ST_SUM;
      c_ST_SUM:      state_d = c_ST_WRITE_RE;
      c_ST_WRITE_RE: if (wr_ok) state_d = c_ST_WRITE_IM;
      c_ST_WRITE_IM: if (wr_ok) state_d = c_ST_IDLE;
      default:       state_d = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= c_ST_IDLE;
      zr_q    <= '0;
      zi_q    <= '0;
      cre_q   <= '0;
      cim_q   <= '0;
      rr_q    <= '0;
      ii_q    <= '0;
      nzi_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        c_ST_IDLE: if (rd_ok) begin
          zr_q  <= i_In_Q;
          cre_q <= i_C_Re;
          cim_q <= i_C_Im;
        end
        c_ST_LOAD_IM: if (rd_ok) zi_q <= i_In_Q;
        c_ST_MUL_II:  rr_q <= prod_q828;
        c_ST_MUL_RI:  ii_q <= prod_q828;
        c_ST_SUM: begin
          // Escaped pixels are written back unchanged so later passes leave them frozen.
          if (escaped) begin
            out_q <= zr_q;
            nzi_q <= zi_q;
            cnt_q <= cnt_q + 1'b1;
          end else begin
            out_q <= new_zr;
            nzi_q <= new_zi;
          end
        end
        c_ST_WRITE_RE: if (wr_ok) out_q <= nzi_q;
        default: ;
      endcase
    end
  end

  assign o_In_Rdreq     = rd_ok;
  assign o_Out_Wrreq    = wr_ok;
  assign o_Out_Data     = out_q;
  assign o_Busy         = (state_q != c_ST_IDLE);
  assign o_Escape_Count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_julia_iterator.sv
// ----------------------------------------------------------------------------
// tb_julia_iterator : directed vector table plus stall/reset sequences.
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_julia_iterator;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic [31:0] i_C_Re, i_C_Im, i_In_Q;
  logic        i_In_Empty, i_Out_Full;
  logic        o_In_Rdreq, o_Out_Wrreq, o_Busy;
  logic [31:0] o_Out_Data;
  logic [19:0] o_Escape_Count;

  julia_iterator dut (
    .i_Clk          (i_Clk),
    .i_Reset        (i_Reset),
    .i_C_Re         (i_C_Re),
    .i_C_Im         (i_C_Im),
    .i_In_Q         (i_In_Q),
    .i_In_Empty     (i_In_Empty),
    .o_In_Rdreq     (o_In_Rdreq),
    .o_Out_Data     (o_Out_Data),
    .o_Out_Wrreq    (o_Out_Wrreq),
    .i_Out_Full     (i_Out_Full),
    .o_Busy         (o_Busy),
    .o_Escape_Count (o_Escape_Count)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [31:0] zr, zi, cre, cim;
    logic [31:0] exp_re, exp_im;
    bit          esc;
  } vec_t;

  vec_t vecs[10];

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;
  int cyc      = 0;

  logic [31:0] out_log[256];
  int          out_cyc[256];
  int          out_cnt = 0;

  always @(posedge i_Clk) cyc <= cyc + 1;

  // Writes are recorded at the falling edge, i.e. the cycle in which they are accepted.
  always @(negedge i_Clk) begin
    if (o_Out_Wrreq && out_cnt < 256) begin
      out_log[out_cnt] = o_Out_Data;
      out_cyc[out_cnt] = cyc;
      out_cnt = out_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rd(input string name);
    int k = 0;
    do begin
      @(negedge i_Clk);
      k++;
    end while (!o_In_Rdreq && k < 50);
    if (!o_In_Rdreq) chk(name, 64'd0, 64'd1);
  endtask

  task automatic send_pair(input vec_t v, input int gap, output int t_zi);
    int base;
    bit bad;
    base = out_cnt;
    i_C_Re = v.cre; i_C_Im = v.cim; i_In_Q = v.zr; i_In_Empty = 1'b0;
    wait_rd("rd_zr_timeout");
    @(posedge i_Clk); #1;
    i_C_Re = ~v.cre; i_C_Im = ~v.cim;
    if (gap > 0) begin
      i_In_Empty = 1'b1;
      bad = 1'b0;
      repeat (gap) begin
        @(negedge i_Clk);
        if (o_In_Rdreq || !o_Busy || out_cnt != base) bad = 1'b1;
      end
      chk("load_im_stall", {63'd0, bad}, 64'd0);
      @(posedge i_Clk); #1;
    end
    i_In_Q = v.zi; i_In_Empty = 1'b0;
    wait_rd("rd_zi_timeout");
    t_zi = cyc;
    @(posedge i_Clk); #1;
    i_In_Empty = 1'b1;
  endtask

  task automatic wait_out(input int target);
    int k = 0;
    while (out_cnt < target && k < 100) begin
      @(negedge i_Clk);
      k++;
    end
    @(posedge i_Clk); #1;
    if (out_cnt < target) chk("out_timeout", 64'(out_cnt), 64'(target));
  endtask

  task automatic run_vec(input int idx, input int gap);
    int base, t;
    base = out_cnt;
    send_pair(vecs[idx], gap, t);
    wait_out(base + 2);
    if (vecs[idx].esc) exp_cnt++;
    chk($sformatf("v%0d_re", idx), {32'd0, out_log[base]}, {32'd0, vecs[idx].exp_re});
    chk($sformatf("v%0d_im", idx), {32'd0, out_log[base+1]}, {32'd0, vecs[idx].exp_im});
    chk($sformatf("v%0d_lat_re", idx), 64'(out_cyc[base] - t), 64'd5);
    chk($sformatf("v%0d_lat_im", idx), 64'(out_cyc[base+1] - t), 64'd6);
    chk($sformatf("v%0d_esc_cnt", idx), {44'd0, o_Escape_Count}, 64'(exp_cnt));
    chk($sformatf("v%0d_busy_idle", idx), {63'd0, o_Busy}, 64'd0);
  endtask

  initial begin
    int  base, t;
    bit  bad;

    vecs[0] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[1] = '{32'h08000000, 32'h08000000, 32'hF8000000, 32'h04000000, 32'hF8000000, 32'h0C000000, 1'b0};
    vecs[2] = '{32'h20000000, 32'h00000000, 32'h01000000, 32'h02000000, 32'h20000000, 32'h00000000, 1'b1};
    vecs[3] = '{32'h10000000, 32'h10000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h20000000, 1'b0};
    vecs[4] = '{32'hF0000000, 32'h00000000, 32'h01000000, 32'h00000000, 32'h11000000, 32'h00000000, 1'b0};
    vecs[5] = '{32'h18000000, 32'h08000000, 32'h00000000, 32'h00000000, 32'h20000000, 32'h18000000, 1'b0};
    vecs[6] = '{32'h1FFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 32'h3FFFFFFC, 32'h00000000, 1'b0};
    vecs[7] = '{32'h00000000, 32'hE0000000, 32'h12345678, 32'h00000000, 32'h00000000, 32'hE0000000, 1'b1};
    vecs[8] = '{32'h10000000, 32'h00000000, 32'h78000000, 32'h00000000, 32'h88000000, 32'h00000000, 1'b0};
    vecs[9] = '{32'h10000000, 32'hF8000000, 32'h00000000, 32'h00000000, 32'h0C000000, 32'hF0000000, 1'b0};

    i_Reset = 1'b1; i_In_Empty = 1'b1; i_Out_Full = 1'b0;
    i_In_Q = '0; i_C_Re = '0; i_C_Im = '0;
    repeat (3) @(posedge i_Clk);
    #1;
    i_In_Empty = 1'b0;
    @(negedge i_Clk);
    chk("rst_rdreq", {63'd0, o_In_Rdreq}, 64'd0);
    chk("rst_wrreq", {63'd0, o_Out_Wrreq}, 64'd0);
    chk("rst_busy", {63'd0, o_Busy}, 64'd0);
    chk("rst_count", {44'd0, o_Escape_Count}, 64'd0);
    chk("rst_data", {32'd0, o_Out_Data}, 64'd0);
    @(posedge i_Clk); #1;
    i_In_Empty = 1'b1;
    i_Reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, 0);

    // zi withheld for 10 cycles after zr is taken
    run_vec(5, 10);

    // Writeback FIFO full for the first 6 cycles of WRITE_RE
    i_Out_Full = 1'b1;
    base = out_cnt;
    send_pair(vecs[1], 0, t);
    do @(negedge i_Clk); while (cyc < t + 5);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge i_Clk);
      if (o_Out_Wrreq || o_Out_Data !== 32'hF8000000 || !o_Busy) bad = 1'b1;
    end
    chk("full_hold", {63'd0, bad}, 64'd0);
    @(posedge i_Clk); #1;
    i_Out_Full = 1'b0;
    wait_out(base + 2);
    repeat (10) @(posedge i_Clk);
    #1;
    chk("full_write_count", 64'(out_cnt - base), 64'd2);
    chk("full_re", {32'd0, out_log[base]}, 64'h0000_0000_F800_0000);
    chk("full_im", {32'd0, out_log[base+1]}, 64'h0000_0000_0C00_0000);
    chk("full_first_cycle", 64'(out_cyc[base] - t), 64'd11);

    // Reset pulse while the pair sits in MUL_II
    base = out_cnt;
    send_pair(vecs[2], 0, t);
    @(posedge i_Clk); #1;
    i_Reset = 1'b1;
    @(posedge i_Clk); #1;
    exp_cnt = 0;
    @(negedge i_Clk);
    chk("midrst_busy", {63'd0, o_Busy}, 64'd0);
    chk("midrst_count", {44'd0, o_Escape_Count}, 64'd0);
    chk("midrst_data", {32'd0, o_Out_Data}, 64'd0);
    chk("midrst_wrreq", {63'd0, o_Out_Wrreq}, 64'd0);
    @(posedge i_Clk); #1;
    i_Reset = 1'b0;
    repeat (12) @(negedge i_Clk);
    @(posedge i_Clk); #1;
    chk("midrst_no_write", 64'(out_cnt), 64'(base));
    run_vec(1, 0);
    run_vec(2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
